// File: rtl/ahb_config_slave.sv
// AHB-Lite read-only slave exposing five host-loaded 29-bit config words.
// Each word is returned with a 3-bit tag, and a served mask records which words have been read.
module ahb_config_slave #(
  parameter int unsigned          BUSWIDTH    = 32,
  parameter logic [BUSWIDTH-1:0]  BASE_ADDR   = 32'h00000D00,
  parameter int unsigned          WAIT_STATES = 1
) (
  input  logic                ahb_hclk,
  input  logic                n_rst,
  input  logic                ahb_hsel,
  input  logic [1:0]          ahb_htrans,
  input  logic                ahb_hwrite,
  input  logic [BUSWIDTH-1:0] ahb_haddr,
  output logic [BUSWIDTH-1:0] ahb_hrdata,
  output logic                ahb_hready,
  output logic [1:0]          ahb_hresp,
  input  logic                cfg_wr_en,
  input  logic [2:0]          cfg_idx,
  input  logic [28:0]         cfg_data,
  output logic [4:0]          served_mask,
  output logic                all_served
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RDATA,
    S_ERR1,
    S_ERR2
  } state_t;

  localparam logic [2:0] WAIT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          rd_idx_q;
  logic [BUSWIDTH-1:0] rdata_q;
  logic [28:0]         words_q [5];

  logic [BUSWIDTH-1:0] offset;
  logic                legal_addr;
  logic [2:0]          req_idx;
  logic [2:0]          src_idx;
  logic                accept;
  logic                legal_read;

  // Only the NONSEQ and SEQ encodings start a transfer.
  assign accept     = ahb_hsel && ahb_hready && (ahb_htrans == 2'b10 || ahb_htrans == 2'b11);
  assign offset     = ahb_haddr - BASE_ADDR;
  assign legal_addr = (offset <= BUSWIDTH'(16)) && (offset[1:0] == 2'b00);
  assign req_idx    = offset[4:2];
  assign legal_read = accept && !ahb_hwrite && legal_addr;
  // Data comes straight from the request when there are no wait states.
  assign src_idx    = (state_q == S_WAIT) ? rd_idx_q : req_idx;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_RDATA, S_ERR2: begin
        state_d = S_IDLE;
        if (accept) begin
          if (!legal_read) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = S_RDATA;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) state_d = S_RDATA;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ahb_hclk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      rd_idx_q <= 3'd0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (legal_read) rd_idx_q <= req_idx;
      if (state_d == S_RDATA) rdata_q <= BUSWIDTH'({src_idx + 3'd1, words_q[src_idx]});
    end
  end

  // NOTE: the config words are reset on purpose so a read straight after reset returns a known 0.
  always_ff @(posedge ahb_hclk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 5; i++) words_q[i] <= '0;
      served_mask <= '0;
    end else begin
      if (state_q == S_RDATA) served_mask[rd_idx_q] <= 1'b1;
      // A load on the same edge wins over the served set.
      if (cfg_wr_en && cfg_idx <= 3'd4) begin
        words_q[cfg_idx]     <= cfg_data;
        served_mask[cfg_idx] <= 1'b0;
      end
    end
  end

  assign ahb_hready = (state_q == S_IDLE) || (state_q == S_RDATA) || (state_q == S_ERR2);
  assign ahb_hresp  = (state_q == S_ERR1 || state_q == S_ERR2) ? 2'b01 : 2'b00;
  assign ahb_hrdata = (state_q == S_RDATA) ? rdata_q : '0;
  assign all_served = &served_mask;

endmodule

// File: doc/ahb_config_slave.md
AHB_CONFIG_SLAVE -- requirements
Module: ahb_config_slave

Interface
REQ-001 The module SHALL have parameter BUSWIDTH, default 32, giving the AHB address and data width.
REQ-002 The module SHALL have parameter BASE_ADDR, default 32'h00000D00, giving the byte address of config word 0.
REQ-003 The module SHALL have parameter WAIT_STATES, default 1, legal range 0-7, giving the number of hready-low cycles inserted before each OKAY read data cycle.
REQ-004 The module SHALL have port ahb_hclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port n_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The module SHALL have port ahb_hsel, input, 1 bit: slave select.
REQ-007 The module SHALL have port ahb_htrans, input, 2 bits: transfer kind (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-008 The module SHALL have port ahb_hwrite, input, 1 bit: transfer direction, 1 = write.
REQ-009 The module SHALL have port ahb_haddr, input, BUSWIDTH bits: byte address.
REQ-010 The module SHALL have port ahb_hrdata, output, BUSWIDTH bits: read data.
REQ-011 The module SHALL have port ahb_hready, output, 1 bit: slave ready.
REQ-012 The module SHALL have port ahb_hresp, output, 2 bits: 00 OKAY, 01 ERROR.
REQ-013 The module SHALL have port cfg_wr_en, input, 1 bit: host load strobe.
REQ-014 The module SHALL have port cfg_idx, input, 3 bits: word index to load.
REQ-015 The module SHALL have port cfg_data, input, 29 bits: word value to load.
REQ-016 The module SHALL have port served_mask, output, 5 bits: bit i = word i delivered since its last load.
REQ-017 The module SHALL have port all_served, output, 1 bit: asserted when served_mask == 5'b11111.

Function
REQ-018 The module SHALL hold five 29-bit config words: 0 width, 1 height, 2 readStartAddress, 3 writeStartAddress, 4 filterType.
REQ-019 When cfg_wr_en=1 and cfg_idx<=4, word[cfg_idx] SHALL take cfg_data and served_mask[cfg_idx] SHALL clear on that edge; cfg_idx 5-7 SHALL be ignored.
REQ-020 A transfer SHALL be accepted when ahb_hsel=1, ahb_htrans[1]=1 and ahb_hready=1; ahb_haddr and ahb_hwrite SHALL be registered at acceptance.
REQ-021 IDLE and BUSY transfers, or hsel=0, SHALL receive a zero-wait OKAY response (hready=1, hresp=00).
REQ-022 The FSM SHALL have five states: IDLE, WAIT, RDATA, ERR1 and ERR2.
REQ-023 The FSM states SHALL drive outputs as follows: IDLE hready=1 hresp=00; WAIT hready=0 hresp=00; RDATA hready=1 hresp=00 with hrdata valid; ERR1 hready=0 hresp=01; ERR2 hready=1 hresp=01.
REQ-024 A read is legal when offset = haddr-BASE_ADDR is in {0x00,0x04,0x08,0x0C,0x10}; any other offset (including misaligned) or any write SHALL go to ERR1 then ERR2, with no register changes.
REQ-025 On a legal read, the FSM SHALL go to WAIT and count WAIT_STATES cycles, then go to RDATA; with WAIT_STATES=0 it SHALL go directly to RDATA.
REQ-026 In RDATA, hrdata SHALL equal {3'(i+1), word[i]}, where i = offset>>2 (tags 001..101), and served_mask[i] SHALL set on the edge that leaves RDATA.
REQ-027 Read data SHALL be latched on the edge entering RDATA; a host load of the same word on that edge SHALL NOT be visible (old value returned) and its served_mask clear SHALL take priority over the set.
REQ-028 In IDLE, RDATA and ERR2 a new transfer SHALL be acceptable (pipelined); back-to-back legal reads with WAIT_STATES=0 SHALL sustain one word per cycle.
REQ-029 From RDATA or ERR2 with no new accepted transfer, the FSM SHALL return to IDLE.
REQ-030 hrdata SHALL be 0 in every state except RDATA.

Reset
REQ-031 While n_rst=0, the FSM SHALL be in IDLE.
REQ-032 While n_rst=0, the outputs SHALL be hready=1, hresp=00, hrdata=0, served_mask=0 and all_served=0.
REQ-033 While n_rst=0, all config words SHALL be 0 and the wait counter SHALL be 0.
REQ-034 A reset asserted mid-WAIT or mid-ERR1 SHALL abort the transfer immediately with no data phase completion.

Verification
REQ-035 Load idx0=0x151, then read 0xD00 (WAIT_STATES=1) -> one hready-low cycle, then hrdata=0x20000151 with hresp=00 and served_mask=00001.
REQ-036 Load idx3=0x157C, then read 0xD0C -> hrdata=0x8000157C.
REQ-037 Read 0xD14 and read 0xD02 -> each gives hresp=01 for two cycles (hready 0 then 1) with hrdata=0.
REQ-038 Write transfer to 0xD00 -> ERROR response, and word0 is unchanged.
REQ-039 Five reads 0xD00-0xD10 (WAIT_STATES=0, back-to-back) -> tags 001..101 on consecutive cycles and all_served=1; a subsequent load of idx2 -> served_mask=11011.
REQ-040 Assert n_rst during WAIT -> hready=1, hrdata=0, served_mask=0 at once; a read after release returns tag with value 0.
